// File: rtl/mul_div_seq.sv
// mul_div_seq - sequential signed multiply / divide unit feeding Z_High/Z_Low.
//
// Operand a comes from the Y register, operand b from the bus. A start pulse
// in IDLE latches both operands and the opcode. The unit then iterates one
// bit per clock for WIDTH cycles, applies a sign fix-up and pulses done for
// one cycle. A divide by zero skips the iterations and reports immediately.
//
// Ports:
//   clk          system clock, rising edge
//   clr          synchronous active-low reset, clears all state
//   start        request pulse, honoured only in IDLE
//   op           0 = signed multiply, 1 = signed divide
//   a            multiplicand / dividend
//   b            multiplier / divisor
//   busy         high while iterating or fixing up the result
//   done         one-cycle pulse, result valid
//   div_by_zero  valid with done, set for a divide with b = 0
//   c_data_out   multiply: {hi, lo} product; divide: {remainder, quotient}
module mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] c_data_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]      cnt_reg;
  logic               op_reg;
  // acc_reg: Booth accumulator (one guard bit) or division partial remainder.
  // lo_reg:  Booth multiplier / product low half, or dividend / quotient.
  // opnd_reg: multiplicand, or divisor magnitude.
  logic [WIDTH:0]     acc_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               q1_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               dbz_reg;
  logic [2*WIDTH-1:0] c_data_reg;

  logic               div_zero_now;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH+1:0] booth_shift;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign div_zero_now = op && (b == '0);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!clr) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = div_zero_now ? S_DONE : S_CALC;
      S_CALC:  if (cnt_reg == CW'(WIDTH - 1)) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- outputs (decoded from the state register) ----------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      S_CALC, S_FIX: busy = 1'b1;
      S_DONE:        done = 1'b1;
      default:       ;
    endcase
  end

  assign div_by_zero = dbz_reg;
  assign c_data_out  = c_data_reg;

  // ---------------- datapath helpers ----------------
  always_comb begin
    // The magnitude of -2^(WIDTH-1) wraps to itself, which is the correct
    // unsigned value for the restoring divider.
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;

    // Booth step: inspect {multiplier lsb, previous lsb}, add/subtract the
    // sign-extended multiplicand, then shift the whole register right.
    booth_sum = acc_reg;
    case ({lo_reg[0], q1_reg})
      2'b01:   booth_sum = acc_reg + {opnd_reg[WIDTH-1], opnd_reg};
      2'b10:   booth_sum = acc_reg - {opnd_reg[WIDTH-1], opnd_reg};
      default: ;
    endcase
    booth_shift = {booth_sum[WIDTH], booth_sum, lo_reg};

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    div_shift = {acc_reg[WIDTH-1:0], lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    div_ge    = (div_shift >= {1'b0, opnd_reg});

    // Truncating division: quotient sign = sign(a)^sign(b), remainder
    // follows the dividend. -2^31 / -1 lands on 0x80000000 without help.
    quo_fix = neg_q_reg ? -lo_reg : lo_reg;
    rem_fix = neg_r_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_reg    <= '0;
      op_reg     <= 1'b0;
      acc_reg    <= '0;
      lo_reg     <= '0;
      q1_reg     <= 1'b0;
      opnd_reg   <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dbz_reg    <= 1'b0;
      c_data_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg  <= op;
            cnt_reg <= '0;
            dbz_reg <= div_zero_now;
            acc_reg <= '0;
            q1_reg  <= 1'b0;
            if (div_zero_now) begin
              c_data_reg <= {a, {WIDTH{1'b1}}};
            end else if (op) begin
              lo_reg    <= a_mag;
              opnd_reg  <= b_mag;
              neg_q_reg <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r_reg <= a[WIDTH-1];
            end else begin
              lo_reg   <= b;
              opnd_reg <= a;
            end
          end
        end
        S_CALC: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (op_reg) begin
            acc_reg <= div_ge ? div_diff : div_shift;
            lo_reg  <= {lo_reg[WIDTH-2:0], div_ge};
          end else begin
            acc_reg <= booth_shift[2*WIDTH+1:WIDTH+1];
            lo_reg  <= booth_shift[WIDTH:1];
            q1_reg  <= booth_shift[0];
          end
        end
        S_FIX: begin
          if (op_reg) c_data_reg <= {rem_fix, quo_fix};
          else        c_data_reg <= {acc_reg[WIDTH-1:0], lo_reg};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq - directed self-checking bench for mul_div_seq.
// Each operation is timed from its start edge: samples are taken 1 ns after
// every rising edge, sample 0 being the one right after the start edge.
module tb_mul_div_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] c_data_out;

  int checks = 0;
  int errors = 0;

  mul_div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .c_data_out  (c_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and follow it to completion.
  // stray_k1/stray_k2: sample indices at which a stray start is pulsed (-1 = none).
  task automatic run_op(input string tag, input logic op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [63:0] exp_c,
                        input logic exp_dz, input int stray_k1, input int stray_k2);
    int lat;
    int busy_cnt;
    int exp_lat;
    exp_lat  = exp_dz ? 0 : 33;
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    tick();                       // start edge T
    start = 1'b0;
    a = $urandom; b = $urandom;   // operands must already be latched
    op = ~op_i;
    lat = -1;
    busy_cnt = 0;
    check({tag, ".dz_at_accept"}, 64'(div_by_zero), 64'(exp_dz));
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      if (k == stray_k1 || k == stray_k2) begin
        start = 1'b1; op = 1'b1; a = 32'h0000DEAD; b = 32'h0;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, ".result"}, c_data_out, exp_c);
    check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(exp_dz));
    $display("txn %s: op=%0d a=%h b=%h c_data_out=%h dz=%0d latency=%0d",
             tag, op_i, a_i, b_i, c_data_out, div_by_zero, lat);
    tick();                       // first IDLE cycle after done
    check({tag, ".done_one_cycle"}, 64'(done), 64'd0);
    check({tag, ".result_hold"}, c_data_out, exp_c);
  endtask

  initial begin
    int done_seen;
    clr = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.dz", 64'(div_by_zero), 64'd0);
    check("reset.c", c_data_out, 64'd0);
    clr = 1'b1;
    tick();

    // Multiplies
    run_op("mul_7_m3",   1'b0, 32'd7,         32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0, -1, -1);
    run_op("mul_min_min",1'b0, 32'h80000000,  32'h80000000, 64'h40000000_00000000, 1'b0, -1, -1);
    run_op("mul_max_min",1'b0, 32'h7FFFFFFF,  32'h80000000, 64'hC0000000_80000000, 1'b0, -1, -1);
    run_op("mul_m1_m1",  1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'h00000000_00000001, 1'b0, -1, -1);

    // Divides (back-to-back: each starts in the first IDLE cycle after done)
    run_op("div_100_7",  1'b1, 32'd100,       32'd7,        64'h00000002_0000000E, 1'b0, -1, -1);
    run_op("div_m7_2",   1'b1, 32'hFFFFFFF9,  32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, -1, -1);
    run_op("div_7_m2",   1'b1, 32'd7,         32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, -1, -1);
    run_op("div_min_m1", 1'b1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, -1, -1);

    // Divide by zero, then a normal divide clears the flag
    run_op("div_5_0",    1'b1, 32'd5,         32'd0,        64'h00000005_FFFFFFFF, 1'b1, -1, -1);
    run_op("div_9_3",    1'b1, 32'd9,         32'd3,        64'h00000000_00000003, 1'b0, -1, -1);

    // Stray start pulses during a running multiply are ignored
    run_op("mul_stray",  1'b0, 32'd7,         32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 5, 20);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) done_seen++;
      tick();
    end
    check("mul_stray.no_extra_op", 64'(done_seen), 64'd0);

    // Reset in the middle of CALC aborts without a done pulse
    start = 1'b1; op = 1'b0; a = 32'd12; b = 32'd34;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("abort.busy_before", 64'(busy), 64'd1);
    clr = 1'b0;
    tick();
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.c", c_data_out, 64'd0);
    clr = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_seen++;
      tick();
    end
    check("abort.no_done", 64'(done_seen), 64'd0);
    $display("txn abort: reset mid-CALC, c_data_out=%h", c_data_out);
    run_op("after_abort",1'b0, 32'd12,        32'd34,       64'h00000000_00000198, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
